// File: rtl/multi_button_debouncer.sv
// N-channel push-button debouncer: 2-FF sync, stability filter, strobes.
// Define DEBOUNCE_REPEAT_EN to add hold-to-repeat strobes per channel.
module multi_button_debouncer #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] BTN,
  output logic [N_BTN-1:0] clean,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TOP =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  if (N_BTN < 1 || DEBOUNCE_CYCLES < 2 ||
      REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_chk
    $error("multi_button_debouncer: illegal parameter");
  end

  logic [N_BTN-1:0] s1_q, s1_d;
  logic [N_BTN-1:0] s2_q, s2_d;
  logic [N_BTN-1:0] in_s;
  logic [N_BTN-1:0] clean_q, clean_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] rel_q, rel_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

  // Synchroniser chain and polarity normalisation
  always_comb begin
    s1_d = BTN;
    s2_d = s1_q;
    in_s = BTN_ACTIVE_LOW ? ~s2_q : s2_q;
  end

  // Stability filter: clean follows in_s after an unbroken run
  always_comb begin
    clean_d = clean_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (in_s[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_TOP) begin
          clean_d[i] = in_s[i];
          press_d[i] = in_s[i];
          rel_d[i]   = ~in_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      clean_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      clean_q <= clean_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign clean         = clean_q;
  assign press         = press_q;
  assign release_pulse = rel_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int HOLD_MAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] DLY_TOP =
    HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PER_TOP =
    HOLD_W'(REPEAT_PERIOD - 1);

  logic [HOLD_W-1:0] hold_q [N_BTN];
  logic [HOLD_W-1:0] hold_d [N_BTN];
  logic [N_BTN-1:0]  phase_q, phase_d;
  logic [N_BTN-1:0]  rep_q, rep_d;

  // Hold timer: first strobe after the delay, then one per period
  always_comb begin
    phase_d = phase_q;
    rep_d   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      hold_d[i] = hold_q[i] + 1'b1;
      if (!clean_d[i] || press_d[i]) begin
        hold_d[i]  = '0;
        phase_d[i] = 1'b0;
      end else if (hold_q[i] == (phase_q[i] ? PER_TOP : DLY_TOP)) begin
        hold_d[i]  = '0;
        phase_d[i] = 1'b1;
        rep_d[i]   = 1'b1;
      end
    end
  end

  // Hold timer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      rep_q   <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      phase_q <= phase_d;
      rep_q   <= rep_d;
      for (int i = 0; i < N_BTN; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign repeat_pulse = rep_q;
`else
  assign repeat_pulse = '0;
`endif

endmodule
